// File: rtl/smc_pkg.sv
// Shared definitions for serial_magnitude_comparator: state encodings,
// digit-count helper and the WIDTH/DIGIT elaboration check.
package smc_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMP  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int unsigned smc_num_digits(input int unsigned width,
                                                   input int unsigned digit);
        return width / digit;
    endfunction

endpackage

`ifndef SMC_CHECK_WIDTH
`define SMC_CHECK_WIDTH(w, d) \
    if (((w) % (d)) != 0) begin : g_bad_params \
        $error("serial_magnitude_comparator: WIDTH must be a multiple of DIGIT"); \
    end
`endif

// File: rtl/digit_comparator.sv
// DIGIT chained greater/equal bit cells, MSB of the digit evaluated first.
module digit_comparator #(
    parameter int unsigned DIGIT = 4
) (
    input  logic             gt_in,
    input  logic             eq_in,
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             gt_out,
    output logic             eq_out
);

    logic [DIGIT:0] gt_chain;
    logic [DIGIT:0] eq_chain;

    assign gt_chain[0] = gt_in;
    assign eq_chain[0] = eq_in;

    for (genvar k = 0; k < DIGIT; k++) begin : g_cell
        localparam int unsigned BIT = DIGIT - 1 - k;
        assign gt_chain[k+1] = gt_chain[k] | (eq_chain[k] & a[BIT] & ~b[BIT]);
        assign eq_chain[k+1] = eq_chain[k] & ~(a[BIT] ^ b[BIT]);
    end

    assign gt_out = gt_chain[DIGIT];
    assign eq_out = eq_chain[DIGIT];

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per clock.
// Define SMC_EARLY_EXIT_EN to finish at the first mismatching digit.
module serial_magnitude_comparator
    import smc_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             o_gt,
    output logic             o_eq,
    output logic             o_lt
);

    localparam int unsigned NUM_DIGITS = smc_num_digits(WIDTH, DIGIT);
    localparam int unsigned IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    `SMC_CHECK_WIDTH(WIDTH, DIGIT)

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] x_sh;
    logic [WIDTH-1:0] y_sh;
    logic             gt_run;
    logic             eq_run;
    logic             gt_cell;
    logic             eq_cell;
    logic             last_digit;
    logic             finish;

    digit_comparator #(.DIGIT(DIGIT)) u_digit (
        .gt_in  (gt_run),
        .eq_in  (eq_run),
        .a      (x_sh[WIDTH-1 -: DIGIT]),
        .b      (y_sh[WIDTH-1 -: DIGIT]),
        .gt_out (gt_cell),
        .eq_out (eq_cell)
    );

    assign last_digit = (idx == IDX_W'(NUM_DIGITS - 1));
`ifdef SMC_EARLY_EXIT_EN
    assign finish = last_digit | ~eq_cell;
`else
    assign finish = last_digit;
`endif

    assign in_ready = (state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (in_valid)  state_next = ST_CMP;
            ST_CMP:  if (finish)    state_next = ST_DONE;
            ST_DONE: if (out_ready) state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    // Operands are shifted left so the active digit always sits at the top;
    // signed mode flips both sign bits so the unsigned chain orders them.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            x_sh      <= '0;
            y_sh      <= '0;
            gt_run    <= 1'b0;
            eq_run    <= 1'b1;
            out_valid <= 1'b0;
            o_gt      <= 1'b0;
            o_eq      <= 1'b0;
            o_lt      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        x_sh   <= x ^ (is_signed ? MSB_MASK : '0);
                        y_sh   <= y ^ (is_signed ? MSB_MASK : '0);
                        gt_run <= 1'b0;
                        eq_run <= 1'b1;
                        idx    <= '0;
                    end
                end
                ST_CMP: begin
                    x_sh   <= x_sh << DIGIT;
                    y_sh   <= y_sh << DIGIT;
                    gt_run <= gt_cell;
                    eq_run <= eq_cell;
                    idx    <= idx + IDX_W'(1);
                    if (finish) begin
                        out_valid <= 1'b1;
                        o_gt      <= gt_cell;
                        o_eq      <= eq_cell;
                        o_lt      <= ~gt_cell & ~eq_cell;
                    end
                end
                ST_DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed bench for serial_magnitude_comparator (WIDTH=16, DIGIT=4);
// expected latencies follow SMC_EARLY_EXIT_EN when it is defined.
module tb_serial_magnitude_comparator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic [15:0] y;
    logic        is_signed;
    logic        out_valid;
    logic        out_ready;
    logic        o_gt;
    logic        o_eq;
    logic        o_lt;

    int n_assert = 0;
    int n_fail   = 0;

`ifdef SMC_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    always #5 clk = ~clk;

    serial_magnitude_comparator #(.WIDTH(16), .DIGIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o_gt      (o_gt),
        .o_eq      (o_eq),
        .o_lt      (o_lt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int observed, input int expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // One full transaction; latency is counted in edges from the accept edge.
    task automatic run_cmp(input string tag, input logic [15:0] xa, input logic [15:0] ya,
                           input logic sgn, input logic egt, input logic eeq, input logic elt,
                           input int lat_full, input int lat_early);
        int lat;
        check({tag, ".in_ready"}, int'(in_ready), 1);
        x = xa; y = ya; is_signed = sgn; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        x = 16'($urandom); y = 16'($urandom); is_signed = 1'($urandom);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!out_valid && lat < 20);
        check({tag, ".latency"}, lat, EARLY ? lat_early : lat_full);
        check({tag, ".gt"}, int'(o_gt), int'(egt));
        check({tag, ".eq"}, int'(o_eq), int'(eeq));
        check({tag, ".lt"}, int'(o_lt), int'(elt));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".valid_drop"}, int'(out_valid), 0);
        check({tag, ".idle"}, int'(in_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        x = '0; y = '0; is_signed = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("reset.out_valid", int'(out_valid), 0);
        check("reset.flags", int'({o_gt, o_eq, o_lt}), 0);
        check("reset.in_ready", int'(in_ready), 1);

        run_cmp("eq_1234",      16'h1234, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 4, 4);
        run_cmp("msb_unsigned", 16'h8000, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0, 4, 1);
        run_cmp("msb_signed",   16'h8000, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1, 4, 1);
        run_cmp("neg_signed",   16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1, 4, 1);
        run_cmp("neg_unsigned", 16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 4, 1);
        run_cmp("lsb_digit",    16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1, 4, 4);
        run_cmp("top_digit",    16'hF000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 4, 1);
        run_cmp("neg_neg",      16'hFFFE, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 4, 4);
        run_cmp("eq_signed",    16'h8000, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0, 4, 4);

        // Backpressure: result held for 10 cycles, a new request is ignored.
        x = 16'h0010; y = 16'h0001; is_signed = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) tick();
        check("bp.valid", int'(out_valid), 1);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                x = 16'h0000; y = 16'hFFFF; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            check("bp.hold_valid", int'(out_valid), 1);
            check("bp.hold_flags", int'({o_gt, o_eq, o_lt}), 4);
            check("bp.in_ready", int'(in_ready), 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp.release_valid", int'(out_valid), 0);
        check("bp.release_idle", int'(in_ready), 1);
        run_cmp("bp.next", 16'h0100, 16'h00FF, 1'b0, 1'b1, 1'b0, 1'b0, 4, 2);

        // Reset asserted during the second CMP cycle drops the transaction.
        x = 16'h1234; y = 16'h1235; is_signed = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid.in_ready", int'(in_ready), 1);
        check("rst_mid.flags", int'({o_gt, o_eq, o_lt}), 0);
        for (int i = 0; i < 6; i++) begin
            check("rst_mid.no_valid", int'(out_valid), 0);
            tick();
        end
        run_cmp("after_rst", 16'h00FF, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b1, 4, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
